// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU pipeline stage registers: occupancy encoding
// and default payload widths for each inter-stage latch.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occState_e;

  localparam int unsigned IF_ID_DATA_W  = 64;
  localparam int unsigned IF_ID_CTRL_W  = 1;
  localparam int unsigned ID_EX_DATA_W  = 143;
  localparam int unsigned ID_EX_CTRL_W  = 8;
  localparam int unsigned EX_MEM_DATA_W = 106;
  localparam int unsigned EX_MEM_CTRL_W = 4;
  localparam int unsigned MEM_WB_DATA_W = 71;
  localparam int unsigned MEM_WB_CTRL_W = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter shared by the pipeline performance counters.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage latch with valid/ready handshake, optional skid entry,
// flush-to-bubble and a saturating count of cycles spent holding an unsent entry.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = ID_EX_DATA_W,
  parameter int unsigned CTRL_W  = ID_EX_CTRL_W,
  parameter bit          SKID_EN = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  occState_e         occ;
  logic [DATA_W-1:0] mainData;
  logic [CTRL_W-1:0] mainCtrl;
  logic [DATA_W-1:0] skidData;
  logic [CTRL_W-1:0] skidCtrl;
  logic              inFire;
  logic              outFire;
  logic              holding;

  // With the skid entry, in_ready depends only on held state, cutting the
  // ready path from downstream; without it, a full entry can only be replaced
  // in the same cycle it leaves.
  always_comb begin
    holding     = (occ != OCC_EMPTY);
    out_valid_o = holding & ~stall_i;
    outFire     = out_valid_o & out_ready_i;
    if (SKID_EN) begin
      in_ready_o = (occ != OCC_FULL) & ~stall_i;
    end else begin
      in_ready_o = (~holding | out_ready_i) & ~stall_i;
    end
    inFire      = in_valid_i & in_ready_o;
    out_data_o  = mainData;
    out_ctrl_o  = out_valid_o ? mainCtrl : '0;
    occupancy_o = occ;
  end

  // Flush beats everything; stall needs no branch since it already forces
  // both fire signals low.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      occ      <= OCC_EMPTY;
      mainData <= '0;
      mainCtrl <= '0;
      skidData <= '0;
      skidCtrl <= '0;
    end else if (flush_i) begin
      occ <= OCC_EMPTY;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (inFire) begin
            occ      <= OCC_ONE;
            mainData <= in_data_i;
            mainCtrl <= in_ctrl_i;
          end
        end
        OCC_ONE: begin
          if (inFire && outFire) begin
            mainData <= in_data_i;
            mainCtrl <= in_ctrl_i;
          end else if (inFire && SKID_EN) begin
            occ      <= OCC_FULL;
            skidData <= in_data_i;
            skidCtrl <= in_ctrl_i;
          end else if (outFire) begin
            occ <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (outFire) begin
            occ      <= OCC_ONE;
            mainData <= skidData;
            mainCtrl <= skidCtrl;
          end
        end
        default: occ <= OCC_EMPTY;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) stallCounter (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (holding & ~outFire & ~flush_i),
    .cnt   (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: a skid-buffered instance and
// a single-entry instance with a 2-bit stall counter.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  logic          clk_i = 1'b0;
  logic          rstN  = 1'b0;

  logic          aStall, aFlush, aInValid, aInReady, aOutValid, aOutReady;
  logic [DW-1:0] aInData, aOutData;
  logic [CW-1:0] aInCtrl, aOutCtrl;
  logic [1:0]    aOcc;
  logic [15:0]   aCnt;

  logic          bStall, bFlush, bInValid, bInReady, bOutValid, bOutReady;
  logic [DW-1:0] bInData, bOutData;
  logic [CW-1:0] bInCtrl, bOutCtrl;
  logic [1:0]    bOcc;
  logic [1:0]    bCnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b1), .CNT_W(16)) dutSkid (
    .clk_i(clk_i), .rst_i(rstN), .stall_i(aStall), .flush_i(aFlush),
    .in_valid_i(aInValid), .in_ready_o(aInReady), .in_data_i(aInData), .in_ctrl_i(aInCtrl),
    .out_valid_o(aOutValid), .out_ready_i(aOutReady), .out_data_o(aOutData), .out_ctrl_o(aOutCtrl),
    .occupancy_o(aOcc), .stall_cnt_o(aCnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b0), .CNT_W(2)) dutSingle (
    .clk_i(clk_i), .rst_i(rstN), .stall_i(bStall), .flush_i(bFlush),
    .in_valid_i(bInValid), .in_ready_o(bInReady), .in_data_i(bInData), .in_ctrl_i(bInCtrl),
    .out_valid_o(bOutValid), .out_ready_i(bOutReady), .out_data_o(bOutData), .out_ctrl_o(bOutCtrl),
    .occupancy_o(bOcc), .stall_cnt_o(bCnt)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [DW-1:0] data, input logic [CW-1:0] ctrl,
                               input logic ready, input logic stall, input logic flush);
    aInValid  = valid;
    aInData   = data;
    aInCtrl   = ctrl;
    aOutReady = ready;
    aStall    = stall;
    aFlush    = flush;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    bStall = 1'b0; bFlush = 1'b0; bInValid = 1'b0; bInData = '0; bInCtrl = '0; bOutReady = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    checkOutput("reset_occ", aOcc, 0);
    checkOutput("reset_valid", aOutValid, 0);
    checkOutput("reset_data", aOutData, 0);
    checkOutput("reset_ctrl", aOutCtrl, 0);
    checkOutput("reset_cnt", aCnt, 0);
    #6 rstN = 1'b1;
    tick();

    // Pass-through, back-to-back
    applyStimulus(1'b1, 32'h1, 8'hA5, 1'b1, 1'b0, 1'b0);
    checkOutput("pt_ready0", aInReady, 1);
    checkOutput("pt_valid0", aOutValid, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      applyStimulus((i < 4) ? 1'b1 : 1'b0, DW'(i + 1), 8'hA5, 1'b1, 1'b0, 1'b0);
      checkOutput("pt_valid", aOutValid, 1);
      checkOutput("pt_data", aOutData, i);
      checkOutput("pt_ctrl", aOutCtrl, 8'hA5);
      checkOutput("pt_occ", aOcc, 1);
      checkOutput("pt_ready", aInReady, 1);
    end
    tick();
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("pt_empty_occ", aOcc, 0);
    checkOutput("pt_empty_valid", aOutValid, 0);
    checkOutput("pt_empty_ctrl", aOutCtrl, 0);
    checkOutput("pt_hold_data", aOutData, 32'h4);
    checkOutput("pt_cnt", aCnt, 0);

    // Backpressure into the skid entry
    applyStimulus(1'b1, 32'h11, 8'h5A, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h22, 8'h5B, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_ready_one", aInReady, 1);
    tick();
    applyStimulus(1'b1, 32'h99, 8'h99, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_occ_full", aOcc, 2);
    checkOutput("bp_ready_full", aInReady, 0);
    checkOutput("bp_head", aOutData, 32'h11);
    checkOutput("bp_cnt1", aCnt, 1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_out1_data", aOutData, 32'h11);
    checkOutput("bp_out1_ctrl", aOutCtrl, 8'h5A);
    checkOutput("bp_cnt2", aCnt, 2);
    tick();
    checkOutput("bp_out2_data", aOutData, 32'h22);
    checkOutput("bp_out2_ctrl", aOutCtrl, 8'h5B);
    checkOutput("bp_out2_occ", aOcc, 1);
    tick();
    checkOutput("bp_drained", aOcc, 0);
    checkOutput("bp_cnt_final", aCnt, 2);

    // Flush while full with a coincident input
    applyStimulus(1'b1, 32'h30, 8'h01, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h31, 8'h02, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("fl_full", aOcc, 2);
    applyStimulus(1'b1, 32'h33, 8'h03, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("fl_occ", aOcc, 0);
    checkOutput("fl_valid", aOutValid, 0);
    checkOutput("fl_ctrl", aOutCtrl, 0);
    checkOutput("fl_cnt", aCnt, 3);
    tick();
    checkOutput("fl_no33_valid", aOutValid, 0);
    checkOutput("fl_no33_data", aOutData, 32'h30);

    // Stall for three cycles while holding one entry
    applyStimulus(1'b1, 32'h44, 8'h44, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h45, 8'h45, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("st_valid", aOutValid, 0);
      checkOutput("st_ready", aInReady, 0);
      checkOutput("st_ctrl", aOutCtrl, 0);
      tick();
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("st_cnt", aCnt, 6);
    checkOutput("st_release_valid", aOutValid, 1);
    checkOutput("st_release_data", aOutData, 32'h44);
    tick();
    checkOutput("st_empty", aOcc, 0);
    checkOutput("st_cnt_after", aCnt, 6);

    // Single-entry instance: combinational ready and 2-bit saturation
    bInValid = 1'b1; bInData = 32'h66; bInCtrl = 8'h66; bOutReady = 1'b0;
    #1;
    checkOutput("se_ready_empty", bInReady, 1);
    tick();
    bInData = 32'h67;
    #1;
    checkOutput("se_ready_low", bInReady, 0);
    bOutReady = 1'b1;
    #1;
    checkOutput("se_ready_follow", bInReady, 1);
    bOutReady = 1'b0;
    #1;
    checkOutput("se_ready_back", bInReady, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("se_occ", bOcc, 1);
      if (i == 1) checkOutput("se_cnt_mid", bCnt, 2);
    end
    checkOutput("se_cnt_sat", bCnt, 3);
    checkOutput("se_head", bOutData, 32'h66);
    bInValid = 1'b0; bOutReady = 1'b1;
    tick();
    checkOutput("se_drained", bOcc, 0);
    checkOutput("se_cnt_hold", bCnt, 3);

    // Asynchronous reset mid-cycle while full
    applyStimulus(1'b1, 32'h50, 8'h0F, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h51, 8'h0E, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("ar_full", aOcc, 2);
    checkOutput("ar_cnt_pre", aCnt, 7);
    #1 rstN = 1'b0;
    #1;
    checkOutput("ar_occ", aOcc, 0);
    checkOutput("ar_valid", aOutValid, 0);
    checkOutput("ar_data", aOutData, 0);
    checkOutput("ar_ctrl", aOutCtrl, 0);
    checkOutput("ar_cnt", aCnt, 0);
    #1 rstN = 1'b1;
    applyStimulus(1'b1, 32'h55, 8'h3C, 1'b1, 1'b0, 1'b0);
    checkOutput("ar_pre_valid", aOutValid, 0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("ar_lat_valid", aOutValid, 1);
    checkOutput("ar_lat_data", aOutData, 32'h55);
    checkOutput("ar_lat_ctrl", aOutCtrl, 8'h3C);
    tick();
    checkOutput("ar_done", aOcc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register that generalises the fixed ID/EX latch. It carries a data payload and a separately bubble-able control payload, and adds a valid/ready handshake, an optional 2-entry skid buffer, a flush that inserts a bubble, and a saturating stall-cycle counter. It is instantiated between any two CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB), with the hazard unit driving stall_i and flush_i.

Parameters:
DATA_W, 143, data payload width (regA, regB, PC, imm, RS/RT/RD indices); never cleared by a bubble.
CTRL_W, 8, control payload width (RegDst, ALUOp[1:0], ALUSrc, RegWrite, MemtoReg, MemWrite, MemRead); zeroed whenever the stage holds no valid entry.
SKID_EN, 1, 1 = 2-entry skid buffer with in_ready_o registered-derived; 0 = single entry with in_ready_o combinational from out_ready_i.
CNT_W, 16, stall counter width.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-low reset.
stall_i  in  1  freeze: no transfer on either side this cycle.
flush_i  in  1  discard all held entries (bubble).
in_valid_i  in  1  upstream entry valid.
in_ready_o  out  1  stage can accept.
in_data_i  in  DATA_W  upstream data payload.
in_ctrl_i  in  CTRL_W  upstream control payload.
out_valid_o  out  1  head entry valid.
out_ready_i  in  1  downstream accepts.
out_data_o  out  DATA_W  head data payload.
out_ctrl_o  out  CTRL_W  head control payload; 0 when out_valid_o = 0.
occupancy_o  out  2  number of held entries (0..2).
stall_cnt_o  out  CNT_W  cycles with a held but unsent entry.

Behaviour:
- Reset (rst_i = 0, async): occupancy 0, main and skid registers 0, stall_cnt_o 0, out_valid_o 0, out_ctrl_o 0, out_data_o 0. Reset mid-operation drops all entries immediately, without waiting for a clock edge.
- in_fire = in_valid_i & in_ready_o. out_fire = out_valid_o & out_ready_i.
- out_valid_o = (occ != 0) & ~stall_i.
- out_ctrl_o = out_valid_o ? main_ctrl : 0.
- out_data_o = main_data at all times; it holds its last value when the stage is empty.
- in_ready_o:
  - SKID_EN = 1: (occ != 2) & ~stall_i. No combinational path from out_ready_i.
  - SKID_EN = 0: ((occ == 0) | out_ready_i) & ~stall_i.
- States and transitions (occ):
  - EMPTY: in_fire -> ONE, main <= in.
  - ONE:
    - in_fire & out_fire -> ONE, main <= in.
    - in_fire & ~out_fire -> FULL, skid <= in (SKID_EN = 1 only).
    - ~in_fire & out_fire -> EMPTY.
  - FULL: no in_fire is possible. out_fire -> ONE, main <= skid.
- Ordering is strictly FIFO. With SKID_EN = 0, the FULL state is unreachable.
- flush_i has priority over everything, stall included: next occ = EMPTY and the input is not captured, even if in_fire.
  - out_valid_o and out_fire remain as computed during the flush cycle, so a head entry shown that cycle can transfer.
  - The upstream must treat an in_fire that coincides with flush_i as dropped.
- stall_i: both handshake sides see 0, and all state holds. flush_i & stall_i -> flush wins.
- stall_cnt_o increments when (occ != 0) & ~out_fire & ~flush_i. It saturates at 2^CNT_W-1 and is cleared by reset only.
- Latency: 1 cycle from in_fire to out_valid_o when EMPTY.
- Throughput: 1 entry per cycle under continuous out_ready_i.

Decomposition:
- Shared package pipe_pkg: occupancy encoding constants (OCC_EMPTY = 0, OCC_ONE = 1, OCC_FULL = 2) and default width constants for DATA_W and CTRL_W per stage (ID_EX_DATA_W = 143, ID_EX_CTRL_W = 8, etc.).
- Sub-module sat_counter (parameter W; ports inc, cnt): the saturating counter. It is reused by other performance counters.

Test Plan:
1. Pass-through: SKID_EN = 1, out_ready_i = 1, 4 back-to-back entries data 0x1..0x4, ctrl 0xA5 -> each appears 1 cycle later in order; occupancy_o stays 1; stall_cnt_o = 0.
2. Backpressure: out_ready_i = 0, send 0x11, 0x22 -> occupancy_o = 2 and in_ready_o = 0 next cycle. Raise out_ready_i -> 0x11 then 0x22 emitted; stall_cnt_o = 2 (after a 1-cycle wait, 1 count per held cycle).
3. Flush while FULL with in_valid_i = 1 (data 0x33) -> next cycle occupancy_o = 0, out_valid_o = 0, out_ctrl_o = 0; 0x33 never emitted.
4. Stall: occ = 1 holding 0x44 with out_ready_i = 1 and stall_i = 1 for 3 cycles -> out_valid_o = 0 and in_ready_o = 0 throughout, stall_cnt_o += 3. Deassert -> 0x44 emitted.
5. SKID_EN = 0 and CNT_W = 2: hold a valid entry with out_ready_i = 0 for 6 cycles -> stall_cnt_o saturates at 3. in_ready_o follows out_ready_i combinationally; occupancy_o never exceeds 1.
6. Async reset: assert rst_i low mid-cycle while FULL -> outputs clear immediately without a clock edge; after release, the first entry 0x55 emerges with 1-cycle latency.
